// File: rtl/led_blink_sched_pkg.sv
// Shared types and helpers for the LED blink scheduler.
// Holds the FSM state encoding plus small constant helpers used to size counters.
package led_blink_sched_pkg;

  typedef enum logic [2:0] {
    S_IDLE = 3'd0,
    S_ON   = 3'd1,
    S_OFF  = 3'd2,
    S_GAP  = 3'd3,
    S_DONE = 3'd4
  } state_t;

  // Number of input clocks in one millisecond.
  function automatic int calcDiv(input int clkFreq);
    return clkFreq / 1000;
  endfunction

  // Largest of three phase lengths, used to size the shared millisecond counter.
  function automatic int maxOf3(input int a, input int b, input int c);
    int m;
    m = a;
    if (b > m) m = b;
    if (c > m) m = c;
    return m;
  endfunction

endpackage

// File: rtl/led_blink_sched_rr_arbiter.sv
// Round-robin one-hot picker.
// Scans the request vector starting at the pointer position and wrapping around,
// and grants the first active line. Purely combinational so the caller decides
// when the pick is registered. Also intended for reuse as the bus arbiter.
module rr_arbiter #(
  parameter int N     = 4,
  parameter int PTR_W = (N > 1) ? $clog2(N) : 1
) (
  input  logic [N-1:0]     req_i,
  input  logic [PTR_W-1:0] ptr_i,
  output logic [N-1:0]     gnt_o
);

  logic found;

  // Walk the positions in priority order (ptr, ptr+1, ... with wrap) and keep the first hit.
  always_comb begin
    gnt_o = '0;
    found = 1'b0;
    for (int k = 0; k < N; k++) begin
      for (int i = 0; i < N; i++) begin
        if (!found && req_i[i] && (i == ((int'(ptr_i) + k) % N))) begin
          gnt_o[i] = 1'b1;
          found    = 1'b1;
        end
      end
    end
  end

endmodule

// File: rtl/led_blink_sched.sv
// Shared status-LED scheduler.
// Requesters ask for a burst of blinks; a round-robin arbiter hands the LED to one
// of them at a time, and an FSM paced by a 1 ms prescaler plays ON/OFF blinks
// followed by a dark GAP before signalling completion with a one-cycle done pulse.
module led_blink_sched
  import led_blink_sched_pkg::*;
#(
  parameter int CLK_FREQ = 80000000,
  parameter int NUM_REQ  = 4,
  parameter int CNT_W    = 4,
  parameter int ON_MS    = 100,
  parameter int OFF_MS   = 100,
  parameter int GAP_MS   = 500
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic [NUM_REQ-1:0]       req,
  input  logic [NUM_REQ*CNT_W-1:0] blink_cnt,
  output logic [NUM_REQ-1:0]       grant,
  output logic                     busy,
  output logic                     done,
  output logic                     led
);

  localparam int DIV       = calcDiv(CLK_FREQ);
  localparam int PRESC_W   = $clog2(DIV);
  localparam int PHASE_MAX = maxOf3(ON_MS, OFF_MS, GAP_MS);
  localparam int MS_W      = $clog2(PHASE_MAX + 1);
  localparam int PTR_W     = $clog2(NUM_REQ);

  state_t               state_q, state_d;
  logic [PRESC_W-1:0]   presc_q, presc_d;
  logic [MS_W-1:0]      ms_q, ms_d;
  logic [CNT_W-1:0]     rem_q, rem_d;
  logic [NUM_REQ-1:0]   grant_q, grant_d;
  logic [PTR_W-1:0]     ptr_q, ptr_d;
  logic                 led_q, led_d;

  logic [NUM_REQ-1:0]   pick;
  logic [CNT_W-1:0]     pickCnt;
  logic [PTR_W-1:0]     grantIdx;
  logic [PTR_W-1:0]     nextPtr;
  logic [CNT_W-1:0]     remDec;
  logic                 tick;
  logic                 abortReq;

  rr_arbiter #(
    .N     (NUM_REQ),
    .PTR_W (PTR_W)
  ) u_arb (
    .req_i (req),
    .ptr_i (ptr_q),
    .gnt_o (pick)
  );

  assign tick     = (presc_q == PRESC_W'(DIV - 1));
  assign abortReq = ~|(req & grant_q);
  assign remDec   = rem_q - CNT_W'(1);

  // Select the blink count belonging to whichever requester the arbiter picked.
  always_comb begin
    pickCnt = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      if (pick[i]) pickCnt = blink_cnt[i*CNT_W +: CNT_W];
    end
  end

  // Turn the one-hot grant back into an index so the pointer can move past it.
  always_comb begin
    grantIdx = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      if (grant_q[i]) grantIdx = PTR_W'(i);
    end
    nextPtr = (grantIdx == PTR_W'(NUM_REQ - 1)) ? '0 : grantIdx + PTR_W'(1);
  end

  // Next-state logic: picks a requester in IDLE, times each phase in whole
  // milliseconds, and restarts the prescaler whenever a phase begins off-grid
  // (fresh grant or abort) so every phase is an exact number of clocks.
  always_comb begin
    state_d = state_q;
    presc_d = tick ? '0 : presc_q + PRESC_W'(1);
    ms_d    = ms_q;
    rem_d   = rem_q;
    grant_d = grant_q;
    ptr_d   = ptr_q;
    led_d   = led_q;

    case (state_q)
      S_IDLE: begin
        presc_d = '0;
        ms_d    = '0;
        led_d   = 1'b0;
        if (|req) begin
          grant_d = pick;
          rem_d   = pickCnt;
          if (pickCnt == '0) begin
            state_d = S_DONE;
          end else begin
            state_d = S_ON;
            led_d   = 1'b1;
          end
        end
      end

      S_ON: begin
        if (abortReq) begin
          state_d = S_GAP;
          led_d   = 1'b0;
          presc_d = '0;
          ms_d    = '0;
        end else if (tick) begin
          if (ms_q == MS_W'(ON_MS - 1)) begin
            state_d = S_OFF;
            led_d   = 1'b0;
            ms_d    = '0;
          end else begin
            ms_d = ms_q + MS_W'(1);
          end
        end
      end

      S_OFF: begin
        if (abortReq) begin
          state_d = S_GAP;
          led_d   = 1'b0;
          presc_d = '0;
          ms_d    = '0;
        end else if (tick) begin
          if (ms_q == MS_W'(OFF_MS - 1)) begin
            ms_d  = '0;
            rem_d = remDec;
            if (remDec != '0) begin
              state_d = S_ON;
              led_d   = 1'b1;
            end else begin
              state_d = S_GAP;
            end
          end else begin
            ms_d = ms_q + MS_W'(1);
          end
        end
      end

      S_GAP: begin
        if (tick) begin
          if (ms_q == MS_W'(GAP_MS - 1)) begin
            state_d = S_DONE;
            ms_d    = '0;
          end else begin
            ms_d = ms_q + MS_W'(1);
          end
        end
      end

      S_DONE: begin
        state_d = S_IDLE;
        grant_d = '0;
        ptr_d   = nextPtr;
        led_d   = 1'b0;
        presc_d = '0;
        ms_d    = '0;
      end

      default: begin
        state_d = S_IDLE;
        grant_d = '0;
        led_d   = 1'b0;
        presc_d = '0;
        ms_d    = '0;
      end
    endcase
  end

  // State and output registers; reset clears everything immediately, mid-burst included.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= S_IDLE;
      presc_q <= '0;
      ms_q    <= '0;
      rem_q   <= '0;
      grant_q <= '0;
      ptr_q   <= '0;
      led_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      presc_q <= presc_d;
      ms_q    <= ms_d;
      rem_q   <= rem_d;
      grant_q <= grant_d;
      ptr_q   <= ptr_d;
      led_q   <= led_d;
    end
  end

  assign grant = grant_q;
  assign led   = led_q;
  assign busy  = (state_q != S_IDLE);
  assign done  = (state_q == S_DONE);

endmodule

// File: tb/tb_led_blink_sched.sv
// Bench for the shared LED scheduler.
// A burst-level model predicts grant/busy/done/led from elapsed cycles since the
// grant, and directed scenarios pin that model with hand-counted burst shapes.
module tb_led_blink_sched;

  localparam int CLK_FREQ = 4000;
  localparam int NUM_REQ  = 4;
  localparam int CNT_W    = 4;
  localparam int ON_MS    = 2;
  localparam int OFF_MS   = 2;
  localparam int GAP_MS   = 3;
  localparam int DIV      = CLK_FREQ / 1000;
  localparam int ON_CYC   = ON_MS * DIV;
  localparam int OFF_CYC  = OFF_MS * DIV;
  localparam int GAP_CYC  = GAP_MS * DIV;
  localparam int PERIOD   = ON_CYC + OFF_CYC;

  logic                     clk = 1'b0;
  logic                     reset = 1'b1;
  logic [NUM_REQ-1:0]       req = '0;
  logic [NUM_REQ*CNT_W-1:0] blinkCnt = '0;
  logic [NUM_REQ-1:0]       grant;
  logic                     busy;
  logic                     done;
  logic                     led;

  int checkCount = 0;
  int errorCount = 0;

  // Model state: one active burst described by owner, count, elapsed cycles and abort point.
  bit mActive = 1'b0;
  int mIdx = 0;
  int mCnt = 0;
  int mE = 0;
  int mAbortAt = -1;
  int mPtr = 0;

  int busyC, ledC, pulses, doneC;
  logic [NUM_REQ-1:0] g;

  led_blink_sched #(
    .CLK_FREQ (CLK_FREQ),
    .NUM_REQ  (NUM_REQ),
    .CNT_W    (CNT_W),
    .ON_MS    (ON_MS),
    .OFF_MS   (OFF_MS),
    .GAP_MS   (GAP_MS)
  ) dut (
    .clk       (clk),
    .reset     (reset),
    .req       (req),
    .blink_cnt (blinkCnt),
    .grant     (grant),
    .busy      (busy),
    .done      (done),
    .led       (led)
  );

  always #5 clk = ~clk;

  task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
    checkCount++;
    if (actual !== expected) begin
      errorCount++;
      $display("[TB] FAIL %s actual=%0h expected=%0h at %0t", name, actual, expected, $time);
    end
  endtask

  // Elapsed cycle at which the burst's done pulse is due.
  function automatic int modelEnd();
    if (mAbortAt >= 0) return mAbortAt + GAP_CYC;
    if (mCnt == 0) return 0;
    return mCnt * PERIOD + GAP_CYC;
  endfunction

  function automatic bit modelLed();
    int limit;
    if (!mActive) return 1'b0;
    limit = (mAbortAt >= 0) ? mAbortAt : mCnt * PERIOD;
    return (mE < limit) && ((mE % PERIOD) < ON_CYC);
  endfunction

  // Advance the burst model on every clock edge; reset wipes it like the DUT.
  initial begin
    forever begin
      @(posedge clk or posedge reset);
      if (reset) begin
        mActive = 1'b0;
        mPtr = 0;
      end else if (mActive) begin
        if (mE == modelEnd()) begin
          mActive = 1'b0;
          mPtr = (mIdx + 1) % NUM_REQ;
        end else begin
          if (mAbortAt < 0 && mE < mCnt * PERIOD && !req[mIdx]) mAbortAt = mE + 1;
          mE++;
        end
      end else if (|req) begin
        bit found;
        found = 1'b0;
        for (int k = 0; k < NUM_REQ; k++) begin
          int i;
          i = (mPtr + k) % NUM_REQ;
          if (!found && req[i]) begin
            found = 1'b1;
            mIdx = i;
          end
        end
        mCnt = int'(blinkCnt[mIdx*CNT_W +: CNT_W]);
        mE = 0;
        mAbortAt = -1;
        mActive = 1'b1;
      end
    end
  end

  // Compare every DUT output against the model in the middle of each cycle.
  initial begin
    forever begin
      @(negedge clk);
      if (!reset) begin
        checkOutput("grant", 32'(grant), mActive ? 32'(1 << mIdx) : 32'd0);
        checkOutput("busy", 32'(busy), 32'(mActive));
        checkOutput("done", 32'(done), 32'(mActive && (mE == modelEnd())));
        checkOutput("led", 32'(led), 32'(modelLed()));
        checkOutput("grantOnehot", 32'($countones(grant) <= 1), 32'd1);
      end
    end
  end

  task automatic applyStimulus(input logic [NUM_REQ-1:0] r, input logic [NUM_REQ*CNT_W-1:0] c);
    @(posedge clk);
    #1;
    req = r;
    blinkCnt = c;
  endtask

  // Follow one burst from first busy cycle to the first idle cycle after it,
  // optionally dropping the owner's request after abortAt busy cycles or at done.
  task automatic observeBurst(input int abortAt, input bit dropOnDone,
                              output int bC, output int lC, output int pC,
                              output int dC, output logic [NUM_REQ-1:0] fg);
    bit started, finished, prevLed;
    started = 1'b0;
    finished = 1'b0;
    prevLed = 1'b0;
    bC = 0; lC = 0; pC = 0; dC = 0; fg = '0;
    for (int guard = 0; guard < 3000 && !finished; guard++) begin
      @(negedge clk);
      if (busy) begin
        if (!started) fg = grant;
        started = 1'b1;
        bC++;
        if (led) lC++;
        if (led && !prevLed) pC++;
        prevLed = led;
        if (done) begin
          dC++;
          if (dropOnDone) req = req & ~grant;
        end
        if (abortAt > 0 && bC == abortAt) req = req & ~grant;
      end else if (started) begin
        finished = 1'b1;
      end
    end
    checkOutput("burstFinished", 32'(finished), 32'd1);
  endtask

  initial begin
    repeat (3) @(posedge clk);
    #1;
    checkOutput("resetGrant", 32'(grant), 32'd0);
    checkOutput("resetBusy", 32'(busy), 32'd0);
    checkOutput("resetDone", 32'(done), 32'd0);
    checkOutput("resetLed", 32'(led), 32'd0);
    reset = 1'b0;

    $display("[TB] single blink for requester 0");
    applyStimulus(4'b0001, 16'h0001);
    observeBurst(0, 1'b1, busyC, ledC, pulses, doneC, g);
    checkOutput("t1Grant", 32'(g), 32'h1);
    checkOutput("t1Busy", 32'(busyC), 32'd29);
    checkOutput("t1LedHigh", 32'(ledC), 32'd8);
    checkOutput("t1Pulses", 32'(pulses), 32'd1);
    checkOutput("t1Done", 32'(doneC), 32'd1);

    $display("[TB] three blinks for requester 0");
    applyStimulus(4'b0001, 16'h0003);
    observeBurst(0, 1'b1, busyC, ledC, pulses, doneC, g);
    checkOutput("t2Grant", 32'(g), 32'h1);
    checkOutput("t2Busy", 32'(busyC), 32'd61);
    checkOutput("t2LedHigh", 32'(ledC), 32'd24);
    checkOutput("t2Pulses", 32'(pulses), 32'd3);

    $display("[TB] round robin between requesters 1 and 3");
    applyStimulus(4'b1010, 16'h2020);
    observeBurst(0, 1'b0, busyC, ledC, pulses, doneC, g);
    checkOutput("t3Grant1", 32'(g), 32'h2);
    checkOutput("t3Pulses1", 32'(pulses), 32'd2);
    observeBurst(0, 1'b0, busyC, ledC, pulses, doneC, g);
    checkOutput("t3Grant2", 32'(g), 32'h8);
    observeBurst(0, 1'b1, busyC, ledC, pulses, doneC, g);
    checkOutput("t3Grant3", 32'(g), 32'h2);
    observeBurst(0, 1'b1, busyC, ledC, pulses, doneC, g);
    checkOutput("t3Grant4", 32'(g), 32'h8);

    $display("[TB] zero-count request");
    applyStimulus(4'b0001, 16'h0000);
    observeBurst(0, 1'b1, busyC, ledC, pulses, doneC, g);
    checkOutput("t4Busy", 32'(busyC), 32'd1);
    checkOutput("t4LedHigh", 32'(ledC), 32'd0);
    checkOutput("t4Done", 32'(doneC), 32'd1);

    $display("[TB] abort during first ON");
    applyStimulus(4'b0001, 16'h0002);
    observeBurst(4, 1'b1, busyC, ledC, pulses, doneC, g);
    checkOutput("t5LedHigh", 32'(ledC), 32'd4);
    checkOutput("t5Busy", 32'(busyC), 32'd17);
    checkOutput("t5Done", 32'(doneC), 32'd1);

    $display("[TB] reset in the middle of OFF");
    applyStimulus(4'b0010, 16'h0010);
    repeat (12) @(negedge clk);
    checkOutput("t6BusyBefore", 32'(busy), 32'd1);
    #1;
    reset = 1'b1;
    #1;
    checkOutput("t6Grant", 32'(grant), 32'd0);
    checkOutput("t6Busy", 32'(busy), 32'd0);
    checkOutput("t6Done", 32'(done), 32'd0);
    checkOutput("t6Led", 32'(led), 32'd0);
    req = 4'b0011;
    blinkCnt = 16'h0011;
    @(posedge clk);
    #1;
    reset = 1'b0;
    observeBurst(0, 1'b1, busyC, ledC, pulses, doneC, g);
    checkOutput("t6FirstGrant", 32'(g), 32'h1);
    checkOutput("t6FirstBusy", 32'(busyC), 32'd29);
    observeBurst(0, 1'b1, busyC, ledC, pulses, doneC, g);
    checkOutput("t6SecondGrant", 32'(g), 32'h2);

    repeat (3) @(posedge clk);
    $display("CHECKS %0d ERRORS %0d", checkCount, errorCount);
    $finish;
  end

endmodule
